// File: rtl/txn_generator.sv
// txn_generator: drives LFSR-derived operand pairs (a, b) into an external
// AND-DUT, captures its result and presents {index, expected, actual}
// entries to a scoreboard over a valid/ready handshake.
// Optional build macro: TXN_GEN_ERR_INJECT_EN flips bit 0 of out_expected
// on every entry whose index ends in 2'b11.
module txn_generator #(
   parameter int unsigned NUM_TXN = 16,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [7:0] a,
   output logic [7:0] b,
   input  logic [7:0] dut_y,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_index,
   output logic [7:0] out_expected,
   output logic [7:0] out_actual,
   output logic       busy,
   output logic       done
);

   localparam int unsigned IDX_W    = 8;
   localparam int unsigned LFSR_W   = 16;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_SEND   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t              state, state_d;
   logic [LFSR_W-1:0]   lfsr;
   logic [LFSR_W-1:0]   lfsr_step;
   logic [LFSR_W-1:0]   lfsr_drive;
   logic                start_run;
   logic                advance;
   logic                capture;
   logic                last_entry;
   logic                inject;

   // Fibonacci LFSR step, taps 16,14,13,11
   assign lfsr_step  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   // value whose bytes become a/b on the edge that enters DRIVE
   assign lfsr_drive = start_run ? SEED : lfsr_step;
   assign last_entry = (out_index == LAST_IDX);

`ifdef TXN_GEN_ERR_INJECT_EN
   assign inject = (out_index[1:0] == 2'b11);
`else
   assign inject = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   // next-state and datapath control
   always_comb begin
      state_d   = state;
      start_run = 1'b0;
      advance   = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               start_run = 1'b1;
               state_d   = ST_DRIVE;
            end
         end
         ST_DRIVE:  state_d = ST_SAMPLE;
         ST_SAMPLE: begin
            capture = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (out_ready) begin
               advance = 1'b1;
               state_d = last_entry ? ST_DONE : ST_DRIVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // registered status flags decoded from the upcoming state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         out_valid <= (state_d == ST_SEND);
         busy      <= (state_d == ST_DRIVE) || (state_d == ST_SAMPLE) || (state_d == ST_SEND);
         done      <= (state_d == ST_DONE);
      end
   end

   // LFSR, entry index and operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr      <= SEED;
         out_index <= '0;
         a         <= '0;
         b         <= '0;
      end else begin
         if (start_run)    lfsr <= SEED;
         else if (advance) lfsr <= lfsr_step;

         if (start_run)                    out_index <= '0;
         else if (advance && !last_entry)  out_index <= out_index + IDX_W'(1);

         if (start_run || (advance && !last_entry)) begin
            a <= lfsr_drive[15:8];
            b <= lfsr_drive[7:0];
         end
      end
   end

   // capture DUT result and reference in SAMPLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_expected <= '0;
         out_actual   <= '0;
      end else if (capture) begin
         out_expected <= (a & b) ^ {7'd0, inject};
         out_actual   <= dut_y;
      end
   end

endmodule

// File: tb/tb_txn_generator.sv
// Directed bench for txn_generator driving a behavioural AND-DUT.
module tb_txn_generator;

   localparam int unsigned NUM_TXN = 16;
   localparam logic [15:0] SEED    = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a, b, dut_y;
   logic       out_valid, out_ready;
   logic [7:0] out_index, out_expected, out_actual;
   logic       busy, done;
   logic       stuck;

   int checks = 0;
   int errors = 0;

   txn_generator #(.NUM_TXN(NUM_TXN), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .dut_y(dut_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .out_expected(out_expected), .out_actual(out_actual),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   assign dut_y = stuck ? 8'h00 : (a & b);

   function automatic logic [15:0] step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [7:0] ref_exp(input logic [7:0] ra, input logic [7:0] rb, input int idx);
      logic [7:0] r;
      r = ra & rb;
`ifdef TXN_GEN_ERR_INJECT_EN
      if ((idx % 4) == 3) r[0] = ~r[0];
`else
      if (idx < 0) r = 8'h00;
`endif
      return r;
   endfunction

   task automatic pulse_start;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_valid;
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL wait_valid: out_valid=%0b after %0d cycles, required 1", out_valid, n);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: valid/busy/done=%b required 000", {out_valid, busy, done});
      end
      checks++;
      if ({a, b, out_index, out_expected, out_actual} !== 40'd0) begin
         errors++;
         $display("FAIL reset_data: a=%h b=%h idx=%h exp=%h act=%h required all 0",
                  a, b, out_index, out_expected, out_actual);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL idle_flags: valid/busy/done=%b required 000", {out_valid, busy, done});
      end
   endtask

   task automatic test_first_entries;
      out_ready = 1'b1;
      pulse_start;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || a !== 8'hAC || b !== 8'hE1) begin
         errors++;
         $display("FAIL drive_entry: busy=%b valid=%b a=%h b=%h required 1 0 ac e1", busy, out_valid, a, b);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_early: out_valid=%b required 0 one edge after start", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 8'd0 || out_expected !== 8'hA0 || out_actual !== 8'hA0) begin
         errors++;
         $display("FAIL entry0: valid=%b idx=%0d exp=%h act=%h required 1 0 a0 a0",
                  out_valid, out_index, out_expected, out_actual);
      end
      @(negedge clk);
      wait_valid;
      checks++;
      if (out_index !== 8'd1 || a !== 8'h59 || b !== 8'hC3 || out_expected !== 8'h41 || out_actual !== 8'h41) begin
         errors++;
         $display("FAIL entry1: idx=%0d a=%h b=%h exp=%h act=%h required 1 59 c3 41 41",
                  out_index, a, b, out_expected, out_actual);
      end
      for (int c = 0; c < 200 && !done; c++) @(negedge clk);
   endtask

   task automatic test_full_run;
      logic [15:0] m;
      logic [7:0]  last_a;
      int hs;
      m = SEED; hs = 0; last_a = 8'h00;
      out_ready = 1'b1;
      pulse_start;
      for (int c = 0; c < 300 && !done; c++) begin
         if (out_valid) begin
            checks++;
            if (out_index !== 8'(hs) || a !== m[15:8] || b !== m[7:0] ||
                out_expected !== ref_exp(m[15:8], m[7:0], hs) || out_actual !== (m[15:8] & m[7:0])) begin
               errors++;
               $display("FAIL run_entry: idx=%0d a=%h b=%h exp=%h act=%h required %0d %h %h %h %h",
                        out_index, a, b, out_expected, out_actual, hs, m[15:8], m[7:0],
                        ref_exp(m[15:8], m[7:0], hs), m[15:8] & m[7:0]);
            end
            last_a = m[15:8];
            hs++;
            m = step(m);
         end
         @(negedge clk);
      end
      checks++;
      if (hs !== NUM_TXN || done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL run_end: handshakes=%0d done=%b busy=%b valid=%b required %0d 1 0 0",
                  hs, done, busy, out_valid, NUM_TXN);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1 || a !== last_a) begin
         errors++;
         $display("FAIL done_hold: done=%b a=%h required 1 %h", done, a, last_a);
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] s_idx, s_exp, s_act, s_a;
      out_ready = 1'b0;
      pulse_start;
      wait_valid;
      s_idx = out_index; s_exp = out_expected; s_act = out_actual; s_a = a;
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_index !== s_idx || out_expected !== s_exp ||
             out_actual !== s_act || a !== s_a) begin
            errors++;
            $display("FAIL stall_%0d: valid=%b idx=%0d exp=%h act=%h required 1 %0d %h %h",
                     c, out_valid, out_index, out_expected, out_actual, s_idx, s_exp, s_act);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL release_drop: out_valid=%b required 0", out_valid);
      end
      wait_valid;
      checks++;
      if (out_index !== 8'd1 || a !== 8'h59) begin
         errors++;
         $display("FAIL one_handshake: idx=%0d a=%h required 1 59", out_index, a);
      end
   endtask

   task automatic test_reset_midrun;
      int c;
      out_ready = 1'b1;
      for (c = 0; c < 200; c++) begin
         if (out_valid && out_index == 8'd5) begin
            out_ready = 1'b0;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1 || out_index !== 8'd5) begin
         errors++;
         $display("FAIL reach_idx5: valid=%b idx=%0d required 1 5", out_valid, out_index);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || a !== 8'h00 || out_index !== 8'd0) begin
         errors++;
         $display("FAIL midrun_reset: valid=%b busy=%b a=%h idx=%0d required 0 0 00 0",
                  out_valid, busy, a, out_index);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      pulse_start;
      wait_valid;
      checks++;
      if (out_index !== 8'd0 || a !== 8'hAC || b !== 8'hE1) begin
         errors++;
         $display("FAIL restart: idx=%0d a=%h b=%h required 0 ac e1", out_index, a, b);
      end
   endtask

   task automatic test_stuck_dut;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stuck = 1'b1;
      out_ready = 1'b0;
      pulse_start;
      wait_valid;
      checks++;
      if (out_expected !== 8'hA0 || out_actual !== 8'h00) begin
         errors++;
         $display("FAIL stuck_dut: exp=%h act=%h required a0 00", out_expected, out_actual);
      end
      stuck = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 200 && !done; c++) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL stuck_done: done=%b required 1", done);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; stuck = 1'b0;
      test_reset;
      test_first_entries;
      test_full_run;
      test_backpressure;
      test_reset_midrun;
      test_stuck_dut;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
